// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives PLL resetb, syncs/qualifies pll_lock, gates dom_rst/ready, counts relocks, latches fault; state_dbg mirrors state
module pll_lock_sequencer #(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  input  logic             restart,
  output logic             pll_resetb,
  output logic             dom_rst,
  output logic             ready,
  output logic             fault,
  output logic [CNT_W-1:0] relock_cnt,
  output logic [2:0]       state_dbg
);
  localparam int MAX_AB = RESET_CYCLES > LOCK_TIMEOUT_CYCLES ? RESET_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAXC = MAX_AB > LOCK_STABLE_CYCLES ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [CW-1:0] RST_END = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_END = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_END = CW'(LOCK_STABLE_CYCLES - 1);
  typedef enum logic [2:0] {RESET_PLL = 3'd0, WAIT_LOCK = 3'd1, STABLE = 3'd2, RUN = 3'd3, FAULT = 3'd4} state_t;
  state_t st, nxt;
  logic s1, lock_s;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry, retry_n;
  logic [CNT_W-1:0] relock_n;
  always_comb begin
    nxt = st;
    retry_n = retry;
    relock_n = relock_cnt;
    if (restart) begin
      nxt = RESET_PLL;
      retry_n = '0;
    end else begin
      case (st)
        RESET_PLL: nxt = cnt == RST_END ? WAIT_LOCK : RESET_PLL;
        WAIT_LOCK:
          if (lock_s) nxt = STABLE;
          else if (cnt == TO_END) begin
            retry_n = retry + RW'(1);
            nxt = retry_n == RW'(MAX_RETRIES) ? FAULT : RESET_PLL;
          end
        STABLE:
          if (!lock_s) nxt = WAIT_LOCK;
          else if (cnt == STB_END) begin
            nxt = RUN;
            retry_n = '0;
          end
        RUN:
          if (!lock_s) begin
            nxt = RESET_PLL;
            relock_n = &relock_cnt ? relock_cnt : relock_cnt + CNT_W'(1);
          end
        default: nxt = st;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      lock_s <= 1'b0;
      st <= RESET_PLL;
      cnt <= '0;
      retry <= '0;
      relock_cnt <= '0;
      pll_resetb <= 1'b0;
      dom_rst <= 1'b1;
      ready <= 1'b0;
      fault <= 1'b0;
    end else begin
      s1 <= pll_lock;
      lock_s <= s1;
      st <= nxt;
      cnt <= (nxt != st || restart) ? '0 : cnt + CW'(1);
      retry <= retry_n;
      relock_cnt <= relock_n;
      pll_resetb <= !(nxt == RESET_PLL || nxt == FAULT);
      dom_rst <= nxt != RUN;
      ready <= nxt == RUN;
      fault <= nxt == FAULT;
    end
  end
  assign state_dbg = st;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: self-checking bench with PLL model, reference model, vector table and random stimulus
module tb_pll_lock_sequencer;
  localparam int RC = 4, TO = 32, SC = 8, MR = 2, CW = 2, PLL_DLY = 10;
  typedef struct {
    bit tie;
    logic [2:0] st;
    logic [3:0] outs;
  } vec_t;
  logic clk = 0, rst = 0, pll_lock = 0, restart = 0;
  logic pll_resetb, dom_rst, ready, fault;
  logic [CW-1:0] relock_cnt;
  logic [2:0] state_dbg;
  int checks = 0, errors = 0;
  bit kill = 0, tie0 = 0;
  int pcnt = 0;
  int m_st = 0, m_cnt = 0, m_retry = 0, m_relock = 0;
  bit q1 = 0, q2 = 0;
  always #5 clk = ~clk;
  pll_lock_sequencer #(
    .RESET_CYCLES(RC), .LOCK_TIMEOUT_CYCLES(TO), .LOCK_STABLE_CYCLES(SC),
    .MAX_RETRIES(MR), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .restart(restart),
    .pll_resetb(pll_resetb), .dom_rst(dom_rst), .ready(ready), .fault(fault),
    .relock_cnt(relock_cnt), .state_dbg(state_dbg)
  );
  always @(negedge clk) begin
    if (pll_resetb !== 1'b1) pcnt = 0;
    else if (pcnt < PLL_DLY) pcnt++;
    pll_lock = pcnt >= PLL_DLY && !kill && !tie0;
  end
  always @(posedge clk or posedge rst) begin
    int ns;
    if (rst) begin
      m_st = 0; m_cnt = 0; m_retry = 0; m_relock = 0; q1 = 0; q2 = 0;
    end else begin
      ns = m_st;
      if (restart) begin
        ns = 0;
        m_retry = 0;
      end else if (m_st == 0) begin
        if (m_cnt + 1 == RC) ns = 1;
      end else if (m_st == 1) begin
        if (q2) ns = 2;
        else if (m_cnt + 1 == TO) begin
          m_retry++;
          ns = m_retry == MR ? 4 : 0;
        end
      end else if (m_st == 2) begin
        if (!q2) ns = 1;
        else if (m_cnt + 1 == SC) begin
          ns = 3;
          m_retry = 0;
        end
      end else if (m_st == 3) begin
        if (!q2) begin
          ns = 0;
          if (m_relock < (1 << CW) - 1) m_relock++;
        end
      end
      m_cnt = (ns != m_st || restart) ? 0 : m_cnt + 1;
      m_st = ns;
      q2 = q1;
      q1 = pll_lock;
    end
  end
  always begin
    logic [9:0] act, exp;
    @(posedge clk);
    #2;
    act = {pll_resetb, dom_rst, ready, fault, relock_cnt, state_dbg};
    exp = {m_st != 0 && m_st != 4, m_st != 3, m_st == 3, m_st == 4, CW'(m_relock), 3'(m_st)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model t=%0t got %b want %b (resetb,dom_rst,ready,fault,relock,state)", $time, act, exp);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #3;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic wait_state(input logic [2:0] s, input int limit, input string name);
    int n;
    n = 0;
    while (state_dbg !== s && n < limit) begin
      cyc();
      n++;
    end
    chk(name, state_dbg, s);
  endtask
  task automatic pulse_restart();
    restart = 1;
    cyc();
    restart = 0;
  endtask
  initial begin
    vec_t tbl[5];
    logic [2:0] seq[$];
    logic [2:0] prev;
    int n, w, stab, bad;
    bit saw21, saw212, dropped;
    tbl[0] = '{0, 3'd0, 4'b0100};
    tbl[1] = '{0, 3'd1, 4'b1100};
    tbl[2] = '{0, 3'd2, 4'b1100};
    tbl[3] = '{0, 3'd3, 4'b1010};
    tbl[4] = '{1, 3'd4, 4'b0101};
    #1 rst = 1;
    repeat (3) cyc();
    chk("reset_outputs", {pll_resetb, dom_rst, ready, fault, relock_cnt, state_dbg}, {1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0});
    rst = 0;
    n = 0;
    while (!pll_resetb && n < 50) begin
      cyc();
      n++;
    end
    chk("t1_resetb_low_cycles", n, RC);
    seq.push_back(3'd0);
    seq.push_back(state_dbg);
    stab = 0;
    n = 0;
    while (state_dbg !== 3'd3 && n < 100) begin
      cyc();
      n++;
      if (state_dbg != seq[$]) seq.push_back(state_dbg);
      if (state_dbg == 3'd2) stab++;
    end
    chk("t1_seq_len", seq.size(), 4);
    if (seq.size() == 4) chk("t1_seq", {seq[0], seq[1], seq[2], seq[3]}, {3'd0, 3'd1, 3'd2, 3'd3});
    chk("t1_stable_cycles", stab, SC);
    chk("t1_run_outputs", {ready, dom_rst, pll_resetb}, 3'b101);
    pulse_restart();
    wait_state(3'd2, 100, "t2_reach_stable");
    repeat (4) cyc();
    kill = 1;
    cyc();
    kill = 0;
    saw21 = 0; saw212 = 0; dropped = 0; prev = state_dbg; n = 0;
    while (state_dbg !== 3'd3 && n < 100) begin
      cyc();
      n++;
      if (prev == 3'd2 && state_dbg == 3'd1) saw21 = 1;
      if (saw21 && prev == 3'd1 && state_dbg == 3'd2) saw212 = 1;
      if (!pll_resetb) dropped = 1;
      prev = state_dbg;
    end
    chk("t2_saw_2_1_2", saw212, 1);
    chk("t2_resetb_held", dropped, 0);
    chk("t2_reach_run", state_dbg, 3'd3);
    kill = 1;
    cyc();
    kill = 0;
    wait_state(3'd0, 10, "t3_drop");
    chk("t3_after_drop", {ready, dom_rst, pll_resetb, relock_cnt}, {1'b0, 1'b1, 1'b0, 2'd1});
    n = 0;
    while (!pll_resetb && n < 20) begin
      cyc();
      n++;
    end
    chk("t3_resetb_low_cycles", n, RC);
    wait_state(3'd3, 100, "t3_relock_run");
    tie0 = 1;
    w = 0; n = 0;
    while (state_dbg !== 3'd4 && n < 400) begin
      cyc();
      n++;
      if (state_dbg == 3'd1) w++;
    end
    chk("t4_fault_state", state_dbg, 3'd4);
    chk("t4_wait_cycles", w, MR * TO);
    chk("t4_fault_outputs", {fault, pll_resetb, dom_rst, ready}, 4'b1010);
    bad = 0;
    repeat (1000) begin
      cyc();
      if (pll_resetb !== 1'b0 || fault !== 1'b1 || dom_rst !== 1'b1) bad++;
    end
    chk("t4_fault_hold", bad, 0);
    pulse_restart();
    chk("t4_restart", {fault, state_dbg}, {1'b0, 3'd0});
    tie0 = 0;
    rst = 1;
    cyc();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      wait_state(3'd3, 200, "t5_run");
      kill = 1;
      cyc();
      kill = 0;
      wait_state(3'd0, 10, "t5_drop");
      chk("t5_relock", relock_cnt, i + 1 > 3 ? 3 : i + 1);
    end
    wait_state(3'd3, 200, "t5_run_again");
    pulse_restart();
    chk("t5_relock_after_restart", relock_cnt, 3);
    wait_state(3'd3, 200, "t6_run");
    #1 rst = 1;
    #1 chk("t6_rst_in_run", {pll_resetb, dom_rst, ready, fault, relock_cnt, state_dbg}, {1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0});
    cyc();
    rst = 0;
    tie0 = 1;
    wait_state(3'd4, 400, "t6_fault");
    #1 rst = 1;
    #1 chk("t6_rst_in_fault", {pll_resetb, dom_rst, ready, fault, relock_cnt, state_dbg}, {1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0});
    cyc();
    rst = 0;
    tie0 = 0;
    pulse_restart();
    foreach (tbl[i]) begin
      tie0 = tbl[i].tie;
      wait_state(tbl[i].st, 400, "tbl_reach");
      chk("tbl_outputs", {pll_resetb, dom_rst, ready, fault}, tbl[i].outs);
    end
    tie0 = 0;
    pulse_restart();
    for (int s = 0; s < 50; s++) begin
      int p, len;
      case ($urandom_range(0, 3))
        0: p = 0;
        1: p = 2;
        2: p = 20;
        default: p = 300;
      endcase
      len = $urandom_range(100, 400);
      tie0 = $urandom_range(0, 5) == 0;
      for (int c = 0; c < len; c++) begin
        kill = $urandom_range(0, 999) < p;
        restart = $urandom_range(0, 399) == 0;
        rst = $urandom_range(0, 1999) == 0;
        cyc();
      end
    end
    kill = 0; tie0 = 0; restart = 0; rst = 0;
    repeat (5) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
